// File: rtl/paralelo_serie.sv
// Parallel-to-serial stage: WIDTH-bit words out MSB first, with an idle/comma
// word whenever no payload is accepted and a fixed idle lead-in after reset.
module paralelo_serie #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] IDLE_BYTE = WIDTH'(8'hBC),
    parameter int              LEAD_IDLE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             validIn,
    output logic             readyOut,
    output logic             serialOut,
    output logic             byteStrobe,
    output logic             sendingData
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int IW = (LEAD_IDLE > 1) ? $clog2(LEAD_IDLE + 1) : 1;
    localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
    localparam logic [IW-1:0] LAST_IDLE = IW'(LEAD_IDLE - 1);

    typedef enum logic {LEAD, ACTIVE} state_t;

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] shreg_q,    shreg_d;
    logic [CW-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
    logic             sending_q,  sending_d;
    logic             ready_q,    ready_d;
    logic             strobe_q,   strobe_d;
    logic             load;

    // Ready and strobe are precomputed from the next-state values so they come
    // straight out of flops yet track bitCnt/state with no extra cycle of lag.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        idle_cnt_d = idle_cnt_q;
        sending_d  = sending_q;
        load       = (bit_cnt_q == LAST_BIT);

        if (enb) begin
            if (load) begin
                bit_cnt_d = '0;
                if (state_q == LEAD) begin
                    shreg_d    = IDLE_BYTE;
                    sending_d  = 1'b0;
                    idle_cnt_d = idle_cnt_q + IW'(1);
                    if (idle_cnt_q == LAST_IDLE) begin
                        state_d = ACTIVE;
                    end
                end else if (validIn) begin
                    shreg_d   = dataIn;
                    sending_d = 1'b1;
                end else begin
                    shreg_d   = IDLE_BYTE;
                    sending_d = 1'b0;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + CW'(1);
                shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
            end
        end

        ready_d  = (state_d == ACTIVE) && (bit_cnt_d == LAST_BIT);
        strobe_d = (bit_cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LEAD;
            shreg_q    <= '0;
            bit_cnt_q  <= LAST_BIT;
            idle_cnt_q <= '0;
            sending_q  <= 1'b0;
            ready_q    <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            sending_q  <= sending_d;
            ready_q    <= ready_d;
            strobe_q   <= strobe_d;
        end
    end

    assign serialOut   = shreg_q[WIDTH-1];
    assign readyOut    = ready_q;
    assign byteStrobe  = strobe_q;
    assign sendingData = sending_q;

endmodule

// File: tb/tb_paralelo_serie.sv
// Scoreboard bench for paralelo_serie: a word-level model predicts the bit
// stream, and a negedge monitor pops and compares one bit per enabled edge.
module tb_paralelo_serie;

    localparam int         W     = 8;
    localparam logic [7:0] IDLE  = 8'hBC;
    localparam int         LEAD  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic [7:0] dataIn;
    logic       validIn;
    logic       readyOut;
    logic       serialOut;
    logic       byteStrobe;
    logic       sendingData;

    typedef struct packed {
        logic ser;
        logic strobe;
        logic sending;
    } exp_bit_t;

    exp_bit_t   exp_q[$];
    logic [7:0] src_q[$];
    exp_bit_t   cur;
    int         n_edges;
    int         seen_edges;
    bit         src_enable;
    int         checks;
    int         errors;

    paralelo_serie #(.WIDTH(W), .IDLE_BYTE(IDLE), .LEAD_IDLE(LEAD)) dut (
        .clk        (clk),
        .rst        (rst),
        .enb        (enb),
        .dataIn     (dataIn),
        .validIn    (validIn),
        .readyOut   (readyOut),
        .serialOut  (serialOut),
        .byteStrobe (byteStrobe),
        .sendingData(sendingData)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic actual, input logic required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, required);
        end
    endtask

    // Word-level reference: enabled edges are counted from reset release;
    // every WIDTH-th edge starting at 1 picks a word and queues its bits.
    always @(posedge clk or posedge rst) begin
        logic [7:0] word;
        logic       snd;
        int         k;
        exp_bit_t   e;
        if (rst) begin
            exp_q.delete();
            n_edges = 0;
        end else if (enb) begin
            n_edges++;
            if ((n_edges - 1) % W == 0) begin
                k = (n_edges - 1) / W + 1;
                if (k > LEAD && validIn && src_q.size() != 0) begin
                    word = src_q.pop_front();
                    snd  = 1'b1;
                end else begin
                    word = IDLE;
                    snd  = 1'b0;
                end
                for (int i = 0; i < W; i++) begin
                    e.ser     = word[W-1-i];
                    e.strobe  = (i == 0);
                    e.sending = snd;
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Monitor: one expected bit is consumed per enabled edge; between enabled
    // edges the outputs must hold the last consumed bit.
    always @(negedge clk) begin
        logic exp_ready;
        if (rst) begin
            cur        = '0;
            seen_edges = 0;
        end else if (n_edges != seen_edges) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard_underflow at %0t: got empty queue, expected a bit", $time);
            end else begin
                cur = exp_q.pop_front();
            end
            seen_edges = n_edges;
        end
        exp_ready = !rst && (n_edges % W == 0) && (n_edges / W >= LEAD);
        checkOutput("serialOut",   serialOut,   cur.ser);
        checkOutput("byteStrobe",  byteStrobe,  cur.strobe);
        checkOutput("sendingData", sendingData, cur.sending);
        checkOutput("readyOut",    readyOut,    exp_ready);
    end

    task automatic applyStimulus(input int cycles, input int en_pct);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            enb     = ($urandom_range(99) < en_pct);
            validIn = src_enable && (src_q.size() != 0);
            dataIn  = (src_q.size() != 0) ? src_q[0] : 8'($urandom);
        end
    endtask

    task automatic resetPulse(input int hold_cycles);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstAsync_serialOut",   serialOut,   1'b0);
        checkOutput("rstAsync_readyOut",    readyOut,    1'b0);
        checkOutput("rstAsync_byteStrobe",  byteStrobe,  1'b0);
        checkOutput("rstAsync_sendingData", sendingData, 1'b0);
        repeat (hold_cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cur        = '0;
        seen_edges = 0;
        n_edges    = 0;
        rst        = 1'b1;
        enb        = 1'b1;
        validIn    = 1'b0;
        dataIn     = 8'h00;
        src_enable = 1'b1;

        repeat (3) @(negedge clk);
        #2;
        checkOutput("rstHold_serialOut",   serialOut,   1'b0);
        checkOutput("rstHold_readyOut",    readyOut,    1'b0);
        checkOutput("rstHold_byteStrobe",  byteStrobe,  1'b0);
        checkOutput("rstHold_sendingData", sendingData, 1'b0);
        repeat (5) @(negedge clk);

        src_q.push_back(8'hA5);
        src_q.push_back(8'hFF);
        src_q.push_back(8'h00);
        validIn = 1'b1;
        dataIn  = 8'hA5;
        rst     = 1'b0;
        applyStimulus(64, 100);

        $display("[TB] idle in ACTIVE, then 8'h3C raised mid-word");
        src_enable = 1'b0;
        applyStimulus(21, 100);
        src_q.push_back(8'h3C);
        src_enable = 1'b1;
        applyStimulus(20, 100);

        $display("[TB] enable freeze in the middle of a payload word");
        src_q.push_back(8'hA5);
        applyStimulus(11, 100);
        applyStimulus(5, 0);
        applyStimulus(20, 100);

        $display("[TB] reset pulse during a payload word");
        src_q.push_back(8'h5A);
        src_q.push_back(8'hC3);
        applyStimulus(13, 100);
        resetPulse(2);
        applyStimulus(60, 100);

        $display("[TB] randomized traffic with random enable");
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(3) == 0 && src_q.size() < 4) begin
                src_q.push_back(8'($urandom));
            end
            applyStimulus(1, 70);
        end
        applyStimulus(20, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
